// File: rtl/rscu_multicycle.sv
// rscu_multicycle: multi-cycle RISC-V control FSM with MIO handshake stalls, wait timeout and sticky trap
module rscu_multicycle #(
  parameter int MIO_TIMEOUT = 255,
  parameter bit EXT_OPS     = 1'b1
) (
  input  logic       clk,
  input  logic       RSTN,
  input  logic [4:0] OPcode,
  input  logic [2:0] Fun3,
  input  logic       Fun7,
  input  logic       zero,
  input  logic       MIO_ready,
  output logic [1:0] ALUSrc_A,
  output logic [1:0] ALUSrc_B,
  output logic [1:0] ImmSel,
  output logic [1:0] DatatoReg,
  output logic [1:0] PCSource,
  output logic       PCEN,
  output logic       IRWrite,
  output logic       IorD,
  output logic       RegWrite,
  output logic       MemRead,
  output logic       WR,
  output logic       CPU_MIO,
  output logic [2:0] ALUC,
  output logic [3:0] State,
  output logic       Error
);
  typedef enum logic [3:0] {
    S_IF = 4'd0, S_ID = 4'd1, S_EX = 4'd2, S_WB = 4'd3, S_MA = 4'd4, S_MR = 4'd5,
    S_LW = 4'd6, S_MW = 4'd7, S_BR = 4'd8, S_JAL = 4'd9, S_JALR = 4'd10,
    S_LUI = 4'd11, S_ERR = 4'd15
  } state_t;
  localparam int CW = MIO_TIMEOUT > 1 ? $clog2(MIO_TIMEOUT + 1) : 1;
  state_t cur, nxt;
  logic [CW-1:0] cnt;
  logic waiting, timeout, r_type, alu_ok, br_ok;
  logic pc_write, ir_load, reg_write, mem_write;
  logic [2:0] alu_op;
  logic [1:0] imm_op;
  assign waiting = cur == S_IF || cur == S_MR || cur == S_MW;
  assign timeout = MIO_TIMEOUT != 0 && waiting && !MIO_ready && cnt == CW'(MIO_TIMEOUT);
  assign r_type  = OPcode == 5'b01100;
  assign br_ok   = EXT_OPS || Fun3 == 3'b000;
  assign imm_op  = OPcode == 5'b01000 ? 2'b01 : OPcode == 5'b11000 ? 2'b10 :
                   OPcode == 5'b11011 ? 2'b11 : 2'b00;
  always_comb begin
    alu_op = 3'b010;
    alu_ok = 1'b1;
    if (r_type)
      case ({Fun3, Fun7})
        4'b0000: alu_op = 3'b010;
        4'b0001: alu_op = 3'b110;
        4'b1110: alu_op = 3'b000;
        4'b1100: alu_op = 3'b001;
        4'b0100: alu_op = 3'b111;
        4'b1010: alu_op = 3'b101;
        4'b1000: alu_op = 3'b011;
        default: alu_ok = 1'b0;
      endcase
    else
      case (Fun3)
        3'b000:  alu_op = 3'b010;
        3'b111:  alu_op = 3'b000;
        3'b110:  alu_op = 3'b001;
        3'b010:  alu_op = 3'b111;
        3'b101:  alu_op = 3'b101;
        3'b100:  alu_op = 3'b011;
        default: alu_ok = 1'b0;
      endcase
  end
  always_ff @(posedge clk or negedge RSTN)
    if (!RSTN) cur <= S_IF;
    else cur <= nxt;
  // the wait counter restarts whenever the FSM moves, so each handshake gets its own budget
  always_ff @(posedge clk or negedge RSTN)
    if (!RSTN) cnt <= '0;
    else cnt <= nxt != cur ? '0 : (waiting && !MIO_ready) ? cnt + CW'(1) : cnt;
  always_comb begin
    nxt       = cur;
    ALUSrc_A  = 2'b00;
    ALUSrc_B  = 2'b00;
    ImmSel    = 2'b00;
    DatatoReg = 2'b00;
    PCSource  = 2'b00;
    ALUC      = 3'b010;
    IorD      = 1'b0;
    MemRead   = 1'b0;
    CPU_MIO   = 1'b0;
    pc_write  = 1'b0;
    ir_load   = 1'b0;
    reg_write = 1'b0;
    mem_write = 1'b0;
    case (cur)
      S_IF: begin
        MemRead  = 1'b1;
        ALUSrc_B = 2'b01;
        pc_write = MIO_ready;
        ir_load  = MIO_ready;
        nxt      = MIO_ready ? S_ID : timeout ? S_ERR : S_IF;
      end
      S_ID: begin
        ALUSrc_A = 2'b10;
        ALUSrc_B = 2'b10;
        ImmSel   = imm_op;
        case (OPcode)
          5'b01100, 5'b00100: nxt = S_EX;
          5'b00000, 5'b01000: nxt = S_MA;
          5'b11000:           nxt = S_BR;
          5'b11011:           nxt = S_JAL;
          5'b11001:           nxt = EXT_OPS ? S_JALR : S_ERR;
          5'b01101:           nxt = EXT_OPS ? S_LUI : S_ERR;
          default:            nxt = S_ERR;
        endcase
      end
      S_EX: begin
        ALUSrc_A = 2'b01;
        ALUSrc_B = r_type ? 2'b00 : 2'b10;
        ALUC     = alu_op;
        nxt      = alu_ok ? S_WB : S_ERR;
      end
      S_WB: begin
        reg_write = 1'b1;
        nxt       = S_IF;
      end
      S_MA: begin
        ALUSrc_A = 2'b01;
        ALUSrc_B = 2'b10;
        ImmSel   = OPcode[3] ? 2'b01 : 2'b00;
        nxt      = OPcode[3] ? S_MW : S_MR;
      end
      S_MR: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        CPU_MIO = 1'b1;
        nxt     = MIO_ready ? S_LW : timeout ? S_ERR : S_MR;
      end
      S_LW: begin
        reg_write = 1'b1;
        DatatoReg = 2'b01;
        nxt       = S_IF;
      end
      S_MW: begin
        mem_write = 1'b1;
        IorD      = 1'b1;
        CPU_MIO   = 1'b1;
        nxt       = MIO_ready ? S_IF : timeout ? S_ERR : S_MW;
      end
      S_BR: begin
        ALUSrc_A = 2'b01;
        ALUC     = 3'b110;
        PCSource = 2'b01;
        pc_write = br_ok && (zero ^ Fun3[0]);
        nxt      = br_ok ? S_IF : S_ERR;
      end
      S_JAL: begin
        PCSource  = 2'b01;
        pc_write  = 1'b1;
        reg_write = 1'b1;
        DatatoReg = 2'b10;
        nxt       = S_IF;
      end
      S_JALR: begin
        ALUSrc_A  = 2'b01;
        ALUSrc_B  = 2'b10;
        PCSource  = 2'b10;
        pc_write  = 1'b1;
        reg_write = 1'b1;
        DatatoReg = 2'b10;
        nxt       = S_IF;
      end
      S_LUI: begin
        reg_write = 1'b1;
        DatatoReg = 2'b11;
        nxt       = S_IF;
      end
      default: nxt = S_ERR;
    endcase
  end
  // architectural write strobes are held off for the whole time reset is asserted
  assign PCEN     = RSTN && pc_write;
  assign IRWrite  = RSTN && ir_load;
  assign RegWrite = RSTN && reg_write;
  assign WR       = RSTN && mem_write;
  assign State    = cur;
  assign Error    = cur == S_ERR;
endmodule

// File: tb/tb_rscu_multicycle.sv
// tb_rscu_multicycle: randomized instruction streams against an instruction-level model, plus directed corner cases
module tb_rscu_multicycle;
  localparam int S_IF = 0, S_ID = 1, S_EX = 2, S_WB = 3, S_MA = 4, S_MR = 5, S_LW = 6,
                 S_MW = 7, S_BR = 8, S_JAL = 9, S_JALR = 10, S_LUI = 11, S_ERR = 15;
  logic clk = 1'b0;
  logic rstn = 1'b1;
  logic [4:0] opcode = '0;
  logic [2:0] fun3 = '0;
  logic fun7 = 1'b0, zero = 1'b0, mio_ready = 1'b0;
  logic [1:0] alusrc_a[2], alusrc_b[2], immsel[2], datatoreg[2], pcsource[2];
  logic pcen[2], irwrite[2], iord[2], regwrite[2], memread[2], wr[2], cpu_mio[2], err[2];
  logic [2:0] aluc[2];
  logic [3:0] state[2];
  int nchk = 0, nerr = 0;
  always #5 clk = ~clk;
  rscu_multicycle dut_a (
    .clk(clk), .RSTN(rstn), .OPcode(opcode), .Fun3(fun3), .Fun7(fun7), .zero(zero),
    .MIO_ready(mio_ready), .ALUSrc_A(alusrc_a[0]), .ALUSrc_B(alusrc_b[0]), .ImmSel(immsel[0]),
    .DatatoReg(datatoreg[0]), .PCSource(pcsource[0]), .PCEN(pcen[0]), .IRWrite(irwrite[0]),
    .IorD(iord[0]), .RegWrite(regwrite[0]), .MemRead(memread[0]), .WR(wr[0]),
    .CPU_MIO(cpu_mio[0]), .ALUC(aluc[0]), .State(state[0]), .Error(err[0]));
  rscu_multicycle #(.MIO_TIMEOUT(4), .EXT_OPS(1'b0)) dut_b (
    .clk(clk), .RSTN(rstn), .OPcode(opcode), .Fun3(fun3), .Fun7(fun7), .zero(zero),
    .MIO_ready(mio_ready), .ALUSrc_A(alusrc_a[1]), .ALUSrc_B(alusrc_b[1]), .ImmSel(immsel[1]),
    .DatatoReg(datatoreg[1]), .PCSource(pcsource[1]), .PCEN(pcen[1]), .IRWrite(irwrite[1]),
    .IorD(iord[1]), .RegWrite(regwrite[1]), .MemRead(memread[1]), .WR(wr[1]),
    .CPU_MIO(cpu_mio[1]), .ALUC(aluc[1]), .State(state[1]), .Error(err[1]));
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  function automatic logic [3:0] exp_alu(input bit r, input logic [2:0] f3, input logic f7);
    logic [2:0] c;
    bit ok;
    ok = !(f3 == 3'd1 || f3 == 3'd3) && !(r && f7 && f3 != 3'd0);
    c = f3 == 3'd0 ? ((r && f7) ? 3'b110 : 3'b010) : f3 == 3'd7 ? 3'b000 : f3 == 3'd6 ? 3'b001 :
        f3 == 3'd2 ? 3'b111 : f3 == 3'd5 ? 3'b101 : 3'b011;
    return {ok, c};
  endfunction
  task automatic do_reset;
    rstn = 1'b0;
    mio_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
  endtask
  // plays one instruction on dut_a; expected state trace derived from the instruction class and wait counts
  task automatic run_instr(input logic [4:0] op, input logic [2:0] f3, input logic f7, input logic z,
                           input int wif, input int wmem, output bit trapped, output int ncyc);
    int st[$];
    logic [3:0] ea;
    ea = exp_alu(op == 5'b01100, f3, f7);
    opcode = op; fun3 = f3; fun7 = f7; zero = z;
    repeat (wif + 1) st.push_back(S_IF);
    st.push_back(S_ID);
    case (op)
      5'b01100, 5'b00100: begin st.push_back(S_EX); st.push_back(ea[3] ? S_WB : S_ERR); end
      5'b00000: begin st.push_back(S_MA); repeat (wmem + 1) st.push_back(S_MR); st.push_back(S_LW); end
      5'b01000: begin st.push_back(S_MA); repeat (wmem + 1) st.push_back(S_MW); end
      5'b11000: st.push_back(S_BR);
      5'b11011: st.push_back(S_JAL);
      5'b11001: st.push_back(S_JALR);
      5'b01101: st.push_back(S_LUI);
      default:  st.push_back(S_ERR);
    endcase
    trapped = 0;
    ncyc = 0;
    for (int i = 0; i < st.size(); i++) begin
      int s;
      bit rdy;
      logic [6:0] es, gs;
      s = st[i];
      rdy = (s == S_IF || s == S_MR || s == S_MW) ? !(i + 1 < st.size() && st[i+1] == s) : 1'($urandom);
      mio_ready = rdy;
      @(negedge clk);
      es = {s == S_WB || s == S_LW || s == S_JAL || s == S_JALR || s == S_LUI, s == S_IF || s == S_MR,
            s == S_MW, s == S_IF ? rdy : s == S_BR ? (z ^ f3[0]) : (s == S_JAL || s == S_JALR),
            s == S_IF && rdy, s == S_MR || s == S_MW, s == S_ERR};
      gs = {regwrite[0], memread[0], wr[0], pcen[0], irwrite[0], cpu_mio[0], err[0]};
      nchk++;
      if (state[0] !== 4'(s)) begin
        nerr++;
        $display("FAIL state op=%b cyc=%0d got %0d exp %0d", op, i, state[0], s);
      end
      nchk++;
      if (gs !== es) begin
        nerr++;
        $display("FAIL strobes{rw,mr,wr,pcen,ir,mio,err} op=%b cyc=%0d got %b exp %b", op, i, gs, es);
      end
      if (es[6]) begin
        nchk++;
        if (datatoreg[0] !== (s == S_WB ? 2'b00 : s == S_LW ? 2'b01 : s == S_LUI ? 2'b11 : 2'b10)) begin
          nerr++;
          $display("FAIL datatoreg state=%0d got %b", s, datatoreg[0]);
        end
      end
      if (s == S_EX) begin
        nchk++;
        if (alusrc_a[0] !== 2'b01 || alusrc_b[0] !== (op == 5'b01100 ? 2'b00 : 2'b10) ||
            (ea[3] && aluc[0] !== ea[2:0])) begin
          nerr++;
          $display("FAIL ex_ctrl f3=%b f7=%b got srcA=%b srcB=%b aluc=%b exp aluc %b",
                   f3, f7, alusrc_a[0], alusrc_b[0], aluc[0], ea[2:0]);
        end
      end
      if (s == S_BR || s == S_JAL || s == S_JALR) begin
        nchk++;
        if (pcsource[0] !== (s == S_JALR ? 2'b10 : 2'b01) || (s == S_BR && aluc[0] !== 3'b110)) begin
          nerr++;
          $display("FAIL pcsource state=%0d got %b aluc %b", s, pcsource[0], aluc[0]);
        end
      end
      if (s == S_ID && op inside {5'b00000, 5'b00100, 5'b01000, 5'b11000, 5'b11011, 5'b11001}) begin
        nchk++;
        if (alusrc_a[0] !== 2'b10 || immsel[0] !== (op == 5'b01000 ? 2'b01 : op == 5'b11000 ? 2'b10 :
            op == 5'b11011 ? 2'b11 : 2'b00)) begin
          nerr++;
          $display("FAIL id_immsel op=%b got immsel=%b srcA=%b", op, immsel[0], alusrc_a[0]);
        end
      end
      if (s == S_MR || s == S_MW) begin
        nchk++;
        if (iord[0] !== 1'b1) begin
          nerr++;
          $display("FAIL iord state=%0d got %b exp 1", s, iord[0]);
        end
      end
      if (s == S_ERR) begin
        trapped = 1;
        break;
      end
      ncyc++;
      @(posedge clk);
      #1;
    end
  endtask
  task automatic test_reset;
    #2 rstn = 1'b0;
    mio_ready = 1'b1;
    #1;
    for (int j = 0; j < 2; j++) begin
      nchk++;
      if (state[j] !== 4'd0 || err[j] !== 1'b0 || {pcen[j], irwrite[j], regwrite[j], wr[j]} !== 4'b0) begin
        nerr++;
        $display("FAIL reset dut%0d got state=%0d err=%b strobes=%b", j, state[j], err[j],
                 {pcen[j], irwrite[j], regwrite[j], wr[j]});
      end
    end
    @(posedge clk);
    #1;
    nchk++;
    if (pcen[0] !== 1'b0 || state[0] !== 4'd0) begin
      nerr++;
      $display("FAIL reset_held got pcen=%b state=%0d", pcen[0], state[0]);
    end
    rstn = 1'b1;
    @(negedge clk);
    nchk++;
    if (pcen[0] !== 1'b1 || irwrite[0] !== 1'b1) begin
      nerr++;
      $display("FAIL first_if got pcen=%b irwrite=%b exp 1,1", pcen[0], irwrite[0]);
    end
  endtask
  task automatic test_directed;
    bit t;
    int n;
    logic [4:0] ops[8] = '{5'b01100, 5'b00000, 5'b01000, 5'b11000, 5'b11000, 5'b11001, 5'b01101, 5'b11011};
    logic [2:0] f3s[8] = '{3'b000, 3'b010, 3'b010, 3'b000, 3'b001, 3'b000, 3'b000, 3'b000};
    int wm[8] = '{0, 3, 0, 0, 0, 0, 0, 0};
    int cyc[8] = '{4, 8, 4, 3, 3, 3, 3, 3};
    for (int k = 0; k < 8; k++) begin
      do_reset();
      run_instr(ops[k], f3s[k], 1'b0, 1'b1, 0, wm[k], t, n);
      nchk++;
      if (t || n !== cyc[k] || state[0] !== 4'd0) begin
        nerr++;
        $display("FAIL cycles op=%b got %0d trapped=%b end_state=%0d exp %0d", ops[k], n, t, state[0], cyc[k]);
      end
    end
  endtask
  task automatic test_noext;
    do_reset();
    opcode = 5'b11001; fun3 = 3'b000; mio_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    nchk++;
    if (state[1] !== 4'd15 || err[1] !== 1'b1 || state[0] !== 4'd10 ||
        {memread[1], wr[1], pcen[1], regwrite[1], cpu_mio[1]} !== 5'b0) begin
      nerr++;
      $display("FAIL noext_jalr got b=%0d err=%b a=%0d exp 15,1,10", state[1], err[1], state[0]);
    end
    do_reset();
    opcode = 5'b01101; mio_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    nchk++;
    if (state[1] !== 4'd15 || state[0] !== 4'd11) begin
      nerr++;
      $display("FAIL noext_lui got b=%0d a=%0d exp 15,11", state[1], state[0]);
    end
    do_reset();
    opcode = 5'b11000; fun3 = 3'b001; zero = 1'b1; mio_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    nchk++;
    if (state[1] !== 4'd8) begin
      nerr++;
      $display("FAIL noext_bne_br got %0d exp 8", state[1]);
    end
    @(posedge clk);
    #1;
    nchk++;
    if (state[1] !== 4'd15 || state[0] !== 4'd0) begin
      nerr++;
      $display("FAIL noext_bne_trap got b=%0d a=%0d exp 15,0", state[1], state[0]);
    end
  endtask
  task automatic test_timeout;
    do_reset();
    opcode = 5'b01100;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      nchk++;
      if (state[1] !== 4'd0) begin
        nerr++;
        $display("FAIL timeout_wait cyc=%0d got %0d exp 0", k, state[1]);
      end
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    nchk++;
    if (state[1] !== 4'd15 || err[1] !== 1'b1 ||
        {memread[1], wr[1], pcen[1], irwrite[1], regwrite[1], cpu_mio[1]} !== 6'b0) begin
      nerr++;
      $display("FAIL timeout_trap got state=%0d err=%b", state[1], err[1]);
    end
    mio_ready = 1'b1;
    @(posedge clk);
    #1;
    nchk++;
    if (state[1] !== 4'd15 || pcen[1] !== 1'b0) begin
      nerr++;
      $display("FAIL err_sticky got state=%0d pcen=%b exp 15,0", state[1], pcen[1]);
    end
    rstn = 1'b0;
    #1;
    nchk++;
    if (state[1] !== 4'd0 || err[1] !== 1'b0) begin
      nerr++;
      $display("FAIL err_clear got state=%0d err=%b exp 0,0", state[1], err[1]);
    end
    do_reset();
    repeat (4) @(posedge clk);
    #1 mio_ready = 1'b1;
    @(posedge clk);
    #1;
    nchk++;
    if (state[1] !== 4'd1) begin
      nerr++;
      $display("FAIL ready_wins got %0d exp 1", state[1]);
    end
  endtask
  task automatic test_reset_mw;
    do_reset();
    opcode = 5'b01000; fun3 = 3'b010; mio_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 mio_ready = 1'b0;
    @(negedge clk);
    nchk++;
    if (wr[0] !== 1'b1 || state[0] !== 4'd7) begin
      nerr++;
      $display("FAIL mw_before got wr=%b state=%0d exp 1,7", wr[0], state[0]);
    end
    #1 rstn = 1'b0;
    mio_ready = 1'b1;
    #1;
    nchk++;
    if (wr[0] !== 1'b0 || state[0] !== 4'd0 || pcen[0] !== 1'b0 || irwrite[0] !== 1'b0) begin
      nerr++;
      $display("FAIL mw_abort got wr=%b state=%0d pcen=%b ir=%b", wr[0], state[0], pcen[0], irwrite[0]);
    end
  endtask
  task automatic test_random;
    bit t;
    int n;
    logic [4:0] op;
    logic [2:0] f3;
    logic f7;
    logic [3:0] rt[7] = '{4'b0000, 4'b0001, 4'b1110, 4'b1100, 4'b0100, 4'b1010, 4'b1000};
    logic [2:0] it[6] = '{3'd0, 3'd7, 3'd6, 3'd2, 3'd5, 3'd4};
    do_reset();
    for (int k = 0; k < 300; k++) begin
      f3 = 3'($urandom);
      f7 = 1'($urandom);
      case ($urandom_range(0, 9))
        0: begin op = 5'b01100; {f3, f7} = rt[$urandom_range(0, 6)]; end
        1: begin op = 5'b00100; f3 = it[$urandom_range(0, 5)]; end
        2: begin op = 5'b00000; f3 = 3'b010; end
        3: begin op = 5'b01000; f3 = 3'b010; end
        4: begin op = 5'b11000; f3 = {2'b00, f7}; end
        5: op = 5'b11011;
        6: begin op = 5'b11001; f3 = 3'b000; end
        7: op = 5'b01101;
        8: begin
          op = 5'($urandom);
          while (op inside {5'b01100, 5'b00100, 5'b00000, 5'b01000, 5'b11000, 5'b11011, 5'b11001, 5'b01101})
            op = 5'($urandom);
        end
        default: op = $urandom_range(0, 1) ? 5'b01100 : 5'b00100;
      endcase
      run_instr(op, f3, f7, 1'($urandom), $urandom_range(0, 3), $urandom_range(0, 3), t, n);
      if (t) do_reset();
    end
  endtask
  initial begin
    test_reset();
    test_directed();
    test_noext();
    test_timeout();
    test_reset_mw();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule

// File: doc/rscu_multicycle.md
# rscu_multicycle

Multi-cycle RISC-V control unit, the next generation of the single-cycle RSCUE. It sequences each instruction through fetch, decode, execute, memory and write-back states. It stalls on the MIO_ready memory handshake and can trap into a sticky error state. It sits between the instruction register / MIOBUS and a multi-cycle datapath (PC, OldPC, IR, MDR, A/B, ALUOut registers) inside the RSCPU core.

## Interface
- MIO_TIMEOUT, 255: max consecutive wait cycles with MIO_ready=0 before trap; 0 disables timeout.
- EXT_OPS, 1: 1 enables bne, jalr and lui; 0 makes those opcodes illegal (trap).
- clk  in  1  core clock; state and counter update on rising edge.
- RSTN  in  1  asynchronous, active-low reset.
- OPcode  in  5  inst[6:2], held in IR.
- Fun3  in  3  inst[14:12].
- Fun7  in  1  inst[30].
- zero  in  1  ALU zero flag (live).
- MIO_ready  in  1  memory/bus transfer complete this cycle.
- ALUSrc_A  out  2  00 PC, 01 A (rs1), 10 OldPC.
- ALUSrc_B  out  2  00 B (rs2), 01 const 4, 10 Imm.
- ImmSel  out  2  00 I, 01 S, 10 B, 11 J.
- DatatoReg  out  2  00 ALUOut, 01 MDR, 10 PC, 11 U-imm.
- PCSource  out  2  00 ALU result, 01 ALUOut, 10 ALU result with bit0 cleared.
- PCEN  out  1  PC write enable.
- IRWrite  out  1  IR and OldPC load.
- IorD  out  1  0 address=PC, 1 address=ALUOut.
- RegWrite  out  1  register file write.
- MemRead  out  1  memory read request.
- WR  out  1  memory write request.
- CPU_MIO  out  1  data-memory/IO access in progress.
- ALUC  out  3  add 010, sub 110, and 000, or 001, slt 111, srl 101, xor 011.
- State  out  4  current state code, for debug/VGA.
- Error  out  1  sticky trap flag.

## Operation
- States (code): IF 0, ID 1, EX 2, WB 3, MA 4, MR 5, LW 6, MW 7, BR 8, JAL 9, JALR 10, LUI 11, ERR 15.
- Outputs are decoded from State. Exceptions: PCEN and IRWrite also depend on MIO_ready and zero. Unlisted strobes are 0, and ALUC defaults to add.
- IF:
  - Signals: MemRead=1, IorD=0, ALUSrc_A=00, ALUSrc_B=01, PCSource=00.
  - PCEN=IRWrite=MIO_ready.
  - Stay until MIO_ready=1, then go to ID.
- ID:
  - Signals: ALUSrc_A=10, ALUSrc_B=10, ImmSel per opcode; ALUOut latches the branch/jump target.
  - Next state by opcode:
    - 01100 and 00100 -> EX.
    - 00000 and 01000 -> MA.
    - 11000 -> BR.
    - 11011 -> JAL.
    - 11001 -> JALR (EXT_OPS).
    - 01101 -> LUI (EXT_OPS).
    - Anything else -> ERR.
- EX:
  - Signals: ALUSrc_A=01; ALUSrc_B=00 for R-type, 10 for I-type.
  - R-type ALUC from {Fun3,Fun7}: 0000 add, 0001 sub, 1110 and, 1100 or, 0100 slt, 1010 srl, 1000 xor.
  - I-type ALUC from Fun3: 000 add, 111 and, 110 or, 010 slt, 101 srl, 100 xor.
  - Unlisted funct -> ERR instead of WB.
- WB: RegWrite=1, DatatoReg=00, then IF.
- MA: ALUSrc_A=01, ALUSrc_B=10, ImmSel I (load) or S (store); then MR for load, MW for store.
- MR: MemRead=1, IorD=1, CPU_MIO=1; wait for MIO_ready, then LW.
- LW: RegWrite=1, DatatoReg=01, then IF.
- MW: WR=1, IorD=1, CPU_MIO=1; wait for MIO_ready, then IF.
- BR:
  - Signals: ALUSrc_A=01, ALUSrc_B=00, ALUC=sub, PCSource=01.
  - PCEN = zero XOR Fun3[0] (beq/bne). With EXT_OPS=0, Fun3≠000 -> ERR.
  - Next state IF.
- JAL: PCSource=01, PCEN=1, RegWrite=1, DatatoReg=10 (PC already holds PC+4); then IF.
- JALR: ALUSrc_A=01, ALUSrc_B=10, ImmSel=00, PCSource=10, PCEN=1, RegWrite=1, DatatoReg=10; then IF.
- LUI: RegWrite=1, DatatoReg=11; then IF.
- ERR: all strobes 0, Error=1; left only via RSTN.

## Timing
- RSTN low: State=IF, wait counter=0, Error=0 immediately. PCEN, IRWrite, RegWrite and WR are forced 0 while RSTN is low.
- First IF strobe is allowed on the first rising edge after RSTN deasserts.
- Cycle counts with zero wait states:
  - R/I ALU: 4.
  - Load: 5.
  - Store: 4.
  - Branch, JAL, JALR, LUI: 3.
- Each wait cycle in IF, MR or MW adds 1 cycle.
- Wait counter:
  - Clears on every state change.
  - Increments each cycle spent in IF, MR or MW with MIO_ready=0.
  - When it reaches MIO_TIMEOUT and MIO_ready is still 0, the next edge goes to ERR.
  - MIO_ready=1 on the same edge wins over the timeout.
- WR and MemRead are never high in the same cycle.
- RSTN asserted mid-instruction aborts it with no further strobes.

## Test plan
- Reset, then `add x3,x1,x2` with MIO_ready=1 -> State 0,1,2,3,0; ALUC=010 in EX; RegWrite high only in WB; PCEN high once.
- `lw`, MIO_ready held low 3 cycles in MR -> MR lasts 4 cycles, total 8; RegWrite and DatatoReg=01 one cycle in LW.
- `beq` with zero=1 and `bne` with zero=1 -> PCEN=1 / PCEN=0 in BR; PCSource=01; both take 3 cycles.
- `jalr` with EXT_OPS=1 -> PCSource=10, RegWrite=1, DatatoReg=10 in a single cycle. Same opcode with EXT_OPS=0 -> ERR after ID, Error=1.
- MIO_TIMEOUT=4, MIO_ready stuck 0 in IF -> ERR after 5 cycles, all strobes 0. Pulse RSTN -> State=0, Error=0.
- RSTN asserted during MW -> WR drops immediately and State=0 with no clock edge.
